// File: rtl/fp32_mac_sequencer_if.sv
// Handshake bundle between the dot-product sequencer and its command, operand,
// MAC and result neighbours. The sequencer itself connects through the slave modport.
interface fp32_mac_sequencer_if #(
  parameter int unsigned LEN_W = 16
);
  logic             CMD_VALID_I;
  logic             CMD_READY_O;
  logic [LEN_W-1:0] CMD_LEN_I;
  logic [31:0]      CMD_INIT_I;
  logic             OP_VALID_I;
  logic             OP_READY_O;
  logic [31:0]      OP_ALPHA_I;
  logic [31:0]      OP_BRAVO_I;
  logic [31:0]      MAC_ALPHA_O;
  logic [31:0]      MAC_BRAVO_O;
  logic [31:0]      MAC_ACC_O;
  logic             MAC_VALID_O;
  logic             MAC_READY_I;
  logic [31:0]      MAC_DELTA_I;
  logic             MAC_VALID_I;
  logic             RES_VALID_O;
  logic             RES_READY_I;
  logic [31:0]      RES_DATA_O;
  logic             RES_ERR_O;
  logic             BUSY_O;

  modport slave (
    input  CMD_VALID_I, CMD_LEN_I, CMD_INIT_I,
    input  OP_VALID_I, OP_ALPHA_I, OP_BRAVO_I,
    input  MAC_READY_I, MAC_DELTA_I, MAC_VALID_I,
    input  RES_READY_I,
    output CMD_READY_O, OP_READY_O,
    output MAC_ALPHA_O, MAC_BRAVO_O, MAC_ACC_O, MAC_VALID_O,
    output RES_VALID_O, RES_DATA_O, RES_ERR_O, BUSY_O
  );

  modport master (
    output CMD_VALID_I, CMD_LEN_I, CMD_INIT_I,
    output OP_VALID_I, OP_ALPHA_I, OP_BRAVO_I,
    output MAC_READY_I, MAC_DELTA_I, MAC_VALID_I,
    output RES_READY_I,
    input  CMD_READY_O, OP_READY_O,
    input  MAC_ALPHA_O, MAC_BRAVO_O, MAC_ACC_O, MAC_VALID_O,
    input  RES_VALID_O, RES_DATA_O, RES_ERR_O, BUSY_O
  );
endinterface

// File: rtl/fp32_mac_sequencer.sv
// Dot-product sequencer: streams operand pairs into an external FP32 MAC, chains each
// result back as the next accumulator and returns the final sum (or a timeout error).
module fp32_mac_sequencer #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  fp32_mac_sequencer_if.slave bus
);

  localparam int unsigned      TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [31:0]      mac_alpha_q, mac_alpha_d;
  logic [31:0]      mac_bravo_q, mac_bravo_d;
  logic [31:0]      mac_acc_q, mac_acc_d;
  logic             mac_valid_q, mac_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             res_err_q, res_err_d;
  logic             busy_q, busy_d;
  logic             cmd_ready;
  logic             op_ready;

  // Ready outputs stay low while reset is held so nothing is accepted during reset.
  assign cmd_ready = (state_q == S_IDLE)  && !RST_I;
  assign op_ready  = (state_q == S_FETCH) && !RST_I;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    mac_alpha_d = mac_alpha_q;
    mac_bravo_d = mac_bravo_q;
    mac_acc_d   = mac_acc_q;
    mac_valid_d = mac_valid_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.CMD_VALID_I && cmd_ready) begin
          acc_d     = bus.CMD_INIT_I;
          rem_d     = bus.CMD_LEN_I;
          res_err_d = 1'b0;
          if (bus.CMD_LEN_I == '0) begin
            res_data_d  = bus.CMD_INIT_I;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (bus.OP_VALID_I && op_ready) begin
          mac_alpha_d = bus.OP_ALPHA_I;
          mac_bravo_d = bus.OP_BRAVO_I;
          mac_acc_d   = acc_q;
          mac_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.MAC_READY_I) begin
          mac_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result arriving on the expiry cycle still counts as a good result.
        if (bus.MAC_VALID_I) begin
          acc_d = bus.MAC_DELTA_I;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            res_data_d  = bus.MAC_DELTA_I;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else if (timer_q == TMR_LAST) begin
          res_err_d   = 1'b1;
          res_data_d  = acc_q;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.RES_READY_I) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      timer_q     <= '0;
      mac_alpha_q <= '0;
      mac_bravo_q <= '0;
      mac_acc_q   <= '0;
      mac_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      mac_alpha_q <= mac_alpha_d;
      mac_bravo_q <= mac_bravo_d;
      mac_acc_q   <= mac_acc_d;
      mac_valid_q <= mac_valid_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.CMD_READY_O = cmd_ready;
  assign bus.OP_READY_O  = op_ready;
  assign bus.MAC_ALPHA_O = mac_alpha_q;
  assign bus.MAC_BRAVO_O = mac_bravo_q;
  assign bus.MAC_ACC_O   = mac_acc_q;
  assign bus.MAC_VALID_O = mac_valid_q;
  assign bus.RES_VALID_O = res_valid_q;
  assign bus.RES_DATA_O  = res_data_q;
  assign bus.RES_ERR_O   = res_err_q;
  assign bus.BUSY_O      = busy_q;

endmodule
